// File: rtl/b10_stim_pkg.sv
// Shared opcode field positions, HALT encoding and sequencer state type
// for the b10 stimulus sequencer.
package b10_stim_pkg;

    localparam int unsigned OP_R_BUTTON = 0;
    localparam int unsigned OP_G_BUTTON = 1;
    localparam int unsigned OP_KEY      = 2;
    localparam int unsigned OP_START    = 3;
    localparam int unsigned OP_TEST     = 4;
    localparam int unsigned OP_RTS      = 5;
    localparam int unsigned OP_RTR      = 6;
    localparam int unsigned OP_VIN_LSB  = 7;
    localparam int unsigned OP_OBS      = 11;

    localparam logic [11:0] OP_HALT = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_HS,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/stim_prog_ram.sv
// Program store: DEPTH x 12 array, synchronous write, combinational read.
// Deliberately unreset so a program survives a sequencer reset.
module stim_prog_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [11:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [11:0]       rdata_o
);

    logic [11:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/opcode_seq_ctrl.sv
// Opcode sequencer driving the b10 primary inputs from a loadable program,
// with an rts/rtr handshake stall and sticky timeout abort.
module opcode_seq_ctrl
    import b10_stim_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [11:0]       load_data,
    input  logic              run,
    input  logic              step,
    input  logic              cts,
    input  logic              ctr,
    output logic              r_button,
    output logic              g_button,
    output logic              key,
    output logic              start,
    output logic              test,
    output logic              rts,
    output logic              rtr,
    output logic [3:0]        v_in,
    output logic              obs,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [11:0]       op_q, op_d;
    logic [11:0]       stim_q, stim_d;
    logic [7:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              step_q, step_d;
    logic              mem_we;
    logic [11:0]       mem_rdata;
    seq_state_e        cont_state;
    logic              hs_done;

    stim_prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            stim_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            stim_q  <= stim_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            step_q  <= step_d;
        end
    end

    // A step-launched opcode always parks in IDLE; otherwise run decides.
    assign cont_state = step_q ? ST_IDLE : (run ? ST_FETCH : ST_IDLE);
    assign hs_done    = cts && (!op_q[OP_RTR] || ctr);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        stim_d  = stim_q;
        wait_d  = wait_q;
        err_d   = err_q;
        step_d  = step_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_we = load_en;
                if (run) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b0;
                end else if (step) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                op_d    = mem_rdata;
                state_d = (mem_rdata == OP_HALT) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                stim_d = op_q;
                if (op_q[OP_RTS]) begin
                    state_d = ST_WAIT_HS;
                    wait_d  = '0;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = cont_state;
                end
            end
            ST_WAIT_HS: begin
                if (hs_done) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = cont_state;
                end else if (wait_q == 8'(TIMEOUT)) begin
                    err_d          = 1'b1;
                    stim_d[OP_RTS] = 1'b0;
                    stim_d[OP_RTR] = 1'b0;
                    state_d        = ST_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (step && !run) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    stim_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign r_button    = stim_q[OP_R_BUTTON];
    assign g_button    = stim_q[OP_G_BUTTON];
    assign key         = stim_q[OP_KEY];
    assign start       = stim_q[OP_START];
    assign test        = stim_q[OP_TEST];
    assign rts         = stim_q[OP_RTS];
    assign rtr         = stim_q[OP_RTR];
    assign v_in        = stim_q[OP_VIN_LSB +: 4];
    assign obs         = stim_q[OP_OBS];
    assign pc          = pc_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_opcode_seq_ctrl.sv
// Directed self-checking bench for opcode_seq_ctrl with hand-computed
// expected output words and program counter values.
module tb_opcode_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_data = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        cts = 1'b0;
    logic        ctr = 1'b0;
    logic        r_button, g_button, key, start, test, rts, rtr, obs;
    logic [3:0]  v_in;
    logic [3:0]  pc;
    logic        busy, done, timeout_err;
    logic [11:0] stim;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    opcode_seq_ctrl #(
        .DEPTH   (16),
        .ADDR_W  (4),
        .TIMEOUT (15)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .step        (step),
        .cts         (cts),
        .ctr         (ctr),
        .r_button    (r_button),
        .g_button    (g_button),
        .key         (key),
        .start       (start),
        .test        (test),
        .rts         (rts),
        .rtr         (rtr),
        .v_in        (v_in),
        .obs         (obs),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Reassemble outputs into opcode bit order for whole-word comparison.
    assign stim = {obs, v_in, rtr, rts, test, start, key, g_button, r_button};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic step_pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_stim", 32'(stim), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic run
        load(4'd0, 12'h003);
        load(4'd1, 12'h408);
        load(4'd2, 12'hFFF);
        run = 1'b1;
        tick();
        tick();
        chk("basic_pre_issue", 32'(stim), 32'h0);
        tick();
        chk("basic_op0", 32'(stim), 32'h003);
        chk("basic_pc1", 32'(pc), 32'h1);
        chk("basic_busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("basic_op1", 32'(stim), 32'h408);
        chk("basic_vin", 32'(v_in), 32'h8);
        tick();
        chk("basic_done", 32'(done), 32'h1);
        chk("basic_pc2", 32'(pc), 32'h2);
        chk("basic_halt_hold", 32'(stim), 32'h408);
        run = 1'b0;
        step_pulse();
        chk("exit_done", 32'(done), 32'h0);
        chk("exit_pc", 32'(pc), 32'h0);
        chk("exit_stim", 32'(stim), 32'h0);

        // cts handshake, 5 stalled cycles
        load(4'd0, 12'h020);
        load(4'd1, 12'hFFF);
        cts = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hs_rts_held", 32'(rts), 32'h1);
            chk("hs_pc_stall", 32'(pc), 32'h0);
            tick();
        end
        cts = 1'b1;
        tick();
        chk("hs_pc_adv", 32'(pc), 32'h1);
        tick();
        chk("hs_done", 32'(done), 32'h1);
        chk("hs_err", 32'(timeout_err), 32'h0);
        run = 1'b0;
        cts = 1'b0;
        step_pulse();

        // rtr handshake
        load(4'd0, 12'h060);
        load(4'd1, 12'hFFF);
        cts = 1'b1;
        ctr = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("rtr_stim", 32'(stim), 32'h060);
        for (int i = 0; i < 3; i++) begin
            chk("rtr_stall", 32'(pc), 32'h0);
            tick();
        end
        ctr = 1'b1;
        tick();
        chk("rtr_pc_adv", 32'(pc), 32'h1);
        tick();
        chk("rtr_done", 32'(done), 32'h1);
        run = 1'b0;
        cts = 1'b0;
        ctr = 1'b0;
        step_pulse();

        // Timeout with cts held low
        load(4'd0, 12'h020);
        load(4'd1, 12'hFFF);
        run = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", 32'(timeout_err), 32'h0);
        chk("to_rts_pre", 32'(rts), 32'h1);
        tick();
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_rts", 32'(rts), 32'h0);
        chk("to_done", 32'(done), 32'h1);
        run = 1'b0;
        tick();
        chk("to_sticky", 32'(timeout_err), 32'h1);
        step_pulse();
        chk("to_exit_pc", 32'(pc), 32'h0);
        chk("to_exit_err", 32'(timeout_err), 32'h0);
        chk("to_exit_done", 32'(done), 32'h0);

        // Step mode
        load(4'd0, 12'h001);
        load(4'd1, 12'h002);
        load(4'd2, 12'h004);
        load(4'd3, 12'hFFF);
        for (int k = 0; k < 3; k++) begin
            step_pulse();
            tick();
            tick();
            chk("step_pc", 32'(pc), 32'(k + 1));
            chk("step_idle", 32'({busy, done}), 32'h0);
            chk("step_stim", 32'(stim), 32'(1 << k));
        end

        // Reset in WAIT_HS, then rerun the preserved program
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load(4'd0, 12'h003);
        load(4'd1, 12'h020);
        load(4'd2, 12'hFFF);
        cts = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_wait_rts", 32'(rts), 32'h1);
        chk("mid_wait_pc", 32'(pc), 32'h1);
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("async_stim", 32'(stim), 32'h0);
        chk("async_pc", 32'(pc), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        cts = 1'b1;
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("rerun_op0", 32'(stim), 32'h003);
        tick();
        tick();
        chk("rerun_op1", 32'(stim), 32'h020);
        tick();
        chk("rerun_pc", 32'(pc), 32'h2);
        tick();
        chk("rerun_done", 32'(done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/opcode_seq_ctrl.md
Name: opcode_seq_ctrl

Overview:
Synthesizable stimulus sequencer for the b10 voting-system harness. It holds a small program of 12-bit opcodes and fetches them under a program counter. It drives the b10 primary inputs from registered opcode fields. When an opcode raises rts, it stalls on the DUT's cts/ctr handshake. It replaces the free-running behavioural PC loop, so directed and concolic stimulus can run at gate level and on FPGA.

Parameters:
DEPTH, 16, number of program words (power of two, at least 2)
ADDR_W, 4, log2(DEPTH)
TIMEOUT, 15, maximum handshake wait in cycles before abort (1..255)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  program-memory write strobe (honoured only in IDLE)
load_addr  in  ADDR_W  write address
load_data  in  12  opcode word to write
run  in  1  level; start or continue free-running execution
step  in  1  single-cycle pulse; execute exactly one opcode while run=0
cts  in  1  DUT clear-to-send
ctr  in  1  DUT clear-to-receive
r_button  out  1  opcode[0]
g_button  out  1  opcode[1]
key  out  1  opcode[2]
start  out  1  opcode[3]
test  out  1  opcode[4]
rts  out  1  opcode[5]
rtr  out  1  opcode[6]
v_in  out  4  opcode[10:7]
obs  out  1  opcode[11]
pc  out  ADDR_W  address of the next opcode to fetch
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE
timeout_err  out  1  sticky; set on handshake timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pc=0; all stimulus outputs 0; busy=0; done=0; timeout_err=0; wait counter 0. Program memory is not cleared.
- Opcode 12'hFFF is HALT. It is never driven onto the outputs.
- States: IDLE, FETCH, ISSUE, WAIT_HS, DONE.
- IDLE:
  - load_en writes mem[load_addr].
  - run=1 or a step pulse moves to FETCH. run has priority over step when both are high.
  - If load_en coincides with run/step, the write completes and the transition is still taken.
- FETCH:
  - Reads mem[pc] into the opcode register.
  - HALT: go to DONE; outputs keep their last values; pc unchanged.
  - Otherwise: go to ISSUE.
- ISSUE:
  - All stimulus outputs update together from the opcode register. This is exactly 2 cycles after the start request, or after the previous opcode completes.
  - If opcode[5]=1 (rts): go to WAIT_HS with the wait counter cleared.
  - Otherwise: pc <= pc+1, wrapping from DEPTH-1 to 0.
    - Next state is FETCH if run=1.
    - Next state is IDLE if the opcode was launched by step.
    - Next state is IDLE if run has dropped; pc is retained and execution resumes there.
- WAIT_HS:
  - Outputs are held.
  - Completion condition: cts=1, plus ctr=1 when opcode[6]=1.
  - On completion: pc <= pc+1, then follow the ISSUE continuation rules.
  - Each cycle without completion increments the wait counter.
  - When counter==TIMEOUT without completion: set timeout_err, drive rts and rtr to 0, go to DONE.
  - Dropping run during WAIT_HS has no effect until the handshake resolves.
- DONE:
  - done=1, busy=0.
  - Leaves only on a step pulse with run=0: pc<=0, timeout_err<=0, stimulus outputs<=0, go to IDLE.
- pc wrap: running past DEPTH-1 with no HALT wraps to 0 and continues. Programs must contain a HALT to terminate.
- Reset asserted mid-operation aborts immediately, from any state, with the reset values above.

Decomposition:
- Package b10_stim_pkg holds:
  - opcode bit-position constants (OP_R_BUTTON=0 … OP_OBS=11, OP_VIN_LSB=7);
  - OP_HALT=12'hFFF;
  - the state enum.
- One sub-module, stim_prog_ram: DEPTH x 12 synchronous-write, combinational-read array. It has no reset and is instantiated once.

Test Plan:
- Basic run: load {12'h003, 12'h408, HALT}, pulse run.
  - r_button=1 and g_button=1 appear 2 cycles later.
  - Next opcode drives start=1, v_in=4'h8.
  - Then done=1, pc=2.
- Handshake: load {12'h020, HALT}, run; hold cts=0 for 5 cycles, then raise it.
  - rts=1 is held for 5 cycles.
  - pc advances only after cts=1.
  - done=1, timeout_err=0.
- rtr handshake: opcode 12'h060 with cts=1, ctr=0 for 3 cycles, then ctr=1.
  - Stall lasts 3 cycles, then completes.
- Timeout: opcode 12'h020, cts tied 0, TIMEOUT=15.
  - timeout_err=1 after 15 wait cycles.
  - rts=0, done=1.
  - A later step returns to IDLE with pc=0.
- Step mode: 3 non-HALT words, run=0, three step pulses.
  - pc reads 1, 2, 3 after each step completes.
  - The state returns to IDLE after each step.
- Reset mid-WAIT_HS: drive reset=0 asynchronously.
  - All outputs go to 0 and pc=0 without waiting for a clock edge.
  - Program memory contents are preserved: a re-run reproduces the same sequence.
